// File: rtl/rmap_tx_fifo_arbiter_if.sv
// rmap_tx_fifo_arbiter_if: packet-source request bus and transmit FIFO write port
interface rmap_tx_fifo_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 9
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            reqReady;
    logic [NUM_REQ-1:0]            grant;
    logic                          fifoFull;
    logic                          fifoWrEnable;
    logic [DATA_WIDTH-1:0]         fifoDataIn;
    logic                          timeoutErr;
    modport master (
        output req, reqValid, reqData, fifoFull,
        input  reqReady, grant, fifoWrEnable, fifoDataIn, timeoutErr
    );
    modport slave (
        input  req, reqValid, reqData, fifoFull,
        output reqReady, grant, fifoWrEnable, fifoDataIn, timeoutErr
    );
endinterface

// File: rtl/rmap_tx_fifo_arbiter.sv
// rmap_tx_fifo_arbiter: packet-atomic round-robin sharing of one TX FIFO write port, with stall watchdog
module rmap_tx_fifo_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                  clk,
    input logic                  rst,
    rmap_tx_fifo_arbiter_if.slave bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] EEP = DATA_WIDTH'(1) | (DATA_WIDTH'(1) << (DATA_WIDTH - 1));
    typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;
    state_t                state, state_nxt;
    logic [NUM_REQ-1:0]    grant, grant_nxt;
    logic [IW-1:0]         last_idx, last_nxt, sel;
    logic [TW-1:0]         timer, timer_nxt;
    logic                  found, wr_data;
    logic [DATA_WIDTH-1:0] owner_data;
    assign owner_data = bus.reqData[last_idx*DATA_WIDTH +: DATA_WIDTH];
    assign wr_data    = state == XFER && bus.reqValid[last_idx] && !bus.fifoFull;
    assign bus.grant        = grant;
    assign bus.reqReady     = (state == XFER && !bus.fifoFull) ? NUM_REQ'(1) << last_idx : '0;
    assign bus.fifoWrEnable = wr_data || (state == ABORT && !bus.fifoFull);
    assign bus.fifoDataIn   = state == ABORT ? EEP : owner_data;
    assign bus.timeoutErr   = state == ABORT && !bus.fifoFull;
    // descending scan so the nearest requester after last_idx is the one that sticks
    always_comb begin
        sel   = last_idx;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(last_idx) + k) % NUM_REQ]) begin
                sel   = IW'((int'(last_idx) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_idx;
        timer_nxt = timer;
        case (state)
            IDLE: if (found) begin
                state_nxt = XFER;
                grant_nxt = NUM_REQ'(1) << sel;
                last_nxt  = sel;
                timer_nxt = '0;
            end
            XFER: begin
                timer_nxt = (wr_data || bus.fifoFull) ? '0 : (timer == T_MAX ? timer : timer + 1'b1);
                if (wr_data && owner_data[DATA_WIDTH-1]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (timer_nxt == T_MAX) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: if (!bus.fifoFull) begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_idx <= IW'(NUM_REQ - 1);
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_idx <= last_nxt;
            timer    <= timer_nxt;
        end
    end
endmodule

// File: tb/tb_rmap_tx_fifo_arbiter.sv
// tb_rmap_tx_fifo_arbiter: directed packet scenarios checked against an owner/watchdog reference model
module tb_rmap_tx_fifo_arbiter;
    localparam int N = 3, DW = 9, T = 4;
    localparam logic [DW-1:0] EEP = 9'h101;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    rmap_tx_fifo_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
    rmap_tx_fifo_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int checks = 0, errors = 0;
    logic [DW-1:0] srcq[N][$];
    logic [N-1:0]  hold = '0;
    logic [DW-1:0] wq[$];
    logic [N-1:0]  gq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        int c = 0;
        while (wq.size() < n) begin
            @(posedge clk);
            c++;
            if (c > 300) begin
                checks++;
                errors++;
                $display("FAIL wait_n: fifo writes %0d required %0d", wq.size(), n);
                return;
            end
        end
    endtask

    task automatic chk_words(input string name, input logic [DW-1:0] exp[$]);
        chk({name, "_count"}, 32'(wq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wq.size(); i++) chk(name, 32'(wq[i]), 32'(exp[i]));
    endtask

    task automatic chk_grants(input string name, input logic [N-1:0] exp[$]);
        chk({name, "_count"}, 32'(gq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < gq.size(); i++) chk(name, 32'(gq[i]), 32'(exp[i]));
    endtask

    // Sources: present queue head; a word leaves its queue once seen accepted.
    initial begin : driver
        logic [N-1:0] hs;
        bus.reqValid = '0;
        bus.reqData  = '0;
        forever begin
            @(negedge clk);
            hs = bus.reqValid & bus.reqReady;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            #1;
            for (int i = 0; i < N; i++) begin
                bus.reqValid[i]          = srcq[i].size() > 0 && !hold[i];
                bus.reqData[i*DW +: DW]  = srcq[i].size() > 0 ? srcq[i][0] : '0;
            end
        end
    end

    // Reference: who owns the port, whether it is being aborted, and how long it has idled.
    initial begin : model
        int owner = -1, low = 0, last = N - 1, pick;
        bit aborting = 1'b0, live = 1'b0;
        logic [N-1:0] eg, er, prev_g;
        logic ew, et, full;
        logic [DW-1:0] ed;
        prev_g = '0;
        forever begin
            @(negedge clk);
            full = bus.fifoFull;
            eg = owner < 0 ? '0 : N'(1) << owner;
            er = '0; ew = 1'b0; et = 1'b0; ed = EEP;
            if (owner >= 0 && aborting) begin
                ew = !full;
                et = !full;
            end else if (owner >= 0) begin
                ed = bus.reqData[owner*DW +: DW];
                er = full ? '0 : eg;
                ew = bus.reqValid[owner] && !full;
            end
            if (live) begin
                chk("grant", 32'(bus.grant), 32'(eg));
                chk("reqReady", 32'(bus.reqReady), 32'(er));
                chk("fifoWrEnable", 32'(bus.fifoWrEnable), 32'(ew));
                chk("timeoutErr", 32'(bus.timeoutErr), 32'(et));
                if (ew) chk("fifoDataIn", 32'(bus.fifoDataIn), 32'(ed));
            end
            if (bus.fifoWrEnable === 1'b1) wq.push_back(bus.fifoDataIn);
            if (bus.grant !== prev_g && bus.grant !== '0) gq.push_back(bus.grant);
            prev_g = bus.grant;
            if (rst) begin
                owner = -1; aborting = 1'b0; last = N - 1; low = 0; live = 1'b1;
            end else if (owner < 0) begin
                pick = -1;
                for (int k = N; k >= 1; k--) if (bus.req[(last + k) % N]) pick = (last + k) % N;
                if (pick >= 0) begin owner = pick; last = pick; low = 0; end
            end else if (aborting) begin
                if (!full) begin owner = -1; aborting = 1'b0; end
            end else if (ew) begin
                low = 0;
                if (ed[DW-1]) owner = -1;
            end else if (full) begin
                low = 0;
            end else begin
                low++;
                if (low == T) aborting = 1'b1;
            end
        end
    end

    initial begin : stim
        bus.req = '0;
        bus.fifoFull = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_wr", 32'(bus.fifoWrEnable), 0);
        chk("rst_ready", 32'(bus.reqReady), 0);
        chk("rst_terr", 32'(bus.timeoutErr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // round-robin with all sources requesting; src0 has a second packet to show the wrap
        wq.delete(); gq.delete();
        for (int i = 0; i < N; i++) begin srcq[i].push_back(9'h0AA); srcq[i].push_back(9'h100); end
        srcq[0].push_back(9'h0AA); srcq[0].push_back(9'h100);
        bus.req = 3'b111;
        wait_n(8); #1;
        bus.req = '0;
        chk_words("rr_word", '{9'h0AA, 9'h100, 9'h0AA, 9'h100, 9'h0AA, 9'h100, 9'h0AA, 9'h100});
        chk_grants("rr_grant", '{3'b001, 3'b010, 3'b100, 3'b001});
        // atomicity: request lines change under a packet in flight
        repeat (2) @(posedge clk); #1;
        wq.delete(); gq.delete();
        srcq[0].push_back(9'h011); srcq[0].push_back(9'h022); srcq[0].push_back(9'h100);
        bus.req = 3'b001;
        wait_n(1); #1;
        bus.req = 3'b010;
        srcq[1].push_back(9'h0AA); srcq[1].push_back(9'h100);
        @(negedge clk);
        chk("atom_hold", 32'(bus.grant), 32'(3'b001));
        wait_n(3);
        @(negedge clk);
        chk("atom_dead", 32'(bus.grant), 0);
        @(negedge clk);
        chk("atom_next", 32'(bus.grant), 32'(3'b010));
        wait_n(5); #1;
        bus.req = '0;
        chk_words("atom_word", '{9'h011, 9'h022, 9'h100, 9'h0AA, 9'h100});
        // backpressure longer than the watchdog limit must not abort
        repeat (2) @(posedge clk); #1;
        wq.delete(); gq.delete();
        srcq[1].push_back(9'h031); srcq[1].push_back(9'h032); srcq[1].push_back(9'h100);
        bus.req = 3'b010;
        wait_n(1); #1;
        bus.fifoFull = 1'b1;
        hold[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.reqReady), 0);
            chk("bp_wr", 32'(bus.fifoWrEnable), 0);
            chk("bp_grant", 32'(bus.grant), 32'(3'b010));
            @(posedge clk);
        end
        #1;
        bus.fifoFull = 1'b0;
        hold[1] = 1'b0;
        wait_n(3); #1;
        bus.req = '0;
        chk_words("bp_word", '{9'h031, 9'h032, 9'h100});
        // watchdog abort of a stalled src2; late data stays unwritten
        repeat (2) @(posedge clk); #1;
        wq.delete(); gq.delete();
        srcq[2].push_back(9'h012);
        bus.req = 3'b100;
        wait_n(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("to_early_terr", 32'(bus.timeoutErr), 0);
        chk("to_early_grant", 32'(bus.grant), 32'(3'b100));
        @(posedge clk); #1;
        bus.fifoFull = 1'b1;
        bus.req = '0;
        srcq[2].push_back(9'h034);
        repeat (2) begin
            @(negedge clk);
            chk("to_full_wr", 32'(bus.fifoWrEnable), 0);
            chk("to_full_ready", 32'(bus.reqReady), 0);
            @(posedge clk);
        end
        #1;
        bus.fifoFull = 1'b0;
        @(negedge clk);
        chk("to_eep_wr", 32'(bus.fifoWrEnable), 1);
        chk("to_eep_data", 32'(bus.fifoDataIn), 32'(EEP));
        chk("to_eep_terr", 32'(bus.timeoutErr), 1);
        @(negedge clk);
        chk("to_after_grant", 32'(bus.grant), 0);
        repeat (3) begin
            @(negedge clk);
            chk("to_late_wr", 32'(bus.fifoWrEnable), 0);
        end
        chk_words("to_word", '{9'h012, EEP});
        @(posedge clk); #1;
        srcq[2].delete();
        // reset in the middle of a src1 packet
        repeat (2) @(posedge clk); #1;
        wq.delete(); gq.delete();
        srcq[1].push_back(9'h051); srcq[1].push_back(9'h052); srcq[1].push_back(9'h100);
        bus.req = 3'b010;
        wait_n(1); #1;
        hold[1] = 1'b1;
        #2;
        rst = 1'b1;
        bus.req = 3'b101;
        srcq[1].delete();
        srcq[0].push_back(9'h061); srcq[0].push_back(9'h100);
        srcq[2].push_back(9'h0E1); srcq[2].push_back(9'h100);
        @(posedge clk); #1;
        rst = 1'b0;
        hold[1] = 1'b0;
        @(negedge clk);
        chk("mrst_grant", 32'(bus.grant), 0);
        chk("mrst_wr", 32'(bus.fifoWrEnable), 0);
        chk_words("mrst_pre", '{9'h051});
        wq.delete(); gq.delete();
        wait_n(4); #1;
        bus.req = '0;
        chk_words("mrst_word", '{9'h061, 9'h100, 9'h0E1, 9'h100});
        chk_grants("mrst_grant_seq", '{3'b001, 3'b100});
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
